// File: rtl/zx_mem_arbiter.sv
// zx_mem_arbiter
// Shares one single-port 8-bit RAM between the Z80 CPU bus (tv80n-style
// strobes) and the video fetcher. Video has priority, but a starvation
// limit bounds it. The CPU is held off through cpu_wait_n until its
// access has completed. Each mreq assertion makes exactly one RAM access.
//
// Parameters
//   MEM_LAT     clocks the mem_oe/mem_we strobe is held per access (1..7)
//   STARVE_MAX  video grants allowed while a CPU access waits (1..15)
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   cpu_mreq_n/rd_n/wr_n/rfsh_n     Z80 bus strobes (active low)
//   cpu_a, cpu_dout                 CPU address / write data
//   cpu_di, cpu_wait_n              CPU read data (registered), stall
//   vid_req, vid_addr               video fetch request / address
//   vid_ack, vid_data               video 1-clock ack / read data
//   mem_addr, mem_dout, mem_din     RAM address, write data, read data
//   mem_oe, mem_we                  RAM output enable / write enable
module zx_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_rfsh_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        cpu_wait_n,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_oe,
    output logic        mem_we
);

    typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

    localparam logic [2:0] LAST_CNT   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    state_t     state;
    logic [2:0] cnt;
    logic [3:0] streak;
    logic       cpu_done;
    logic       cpu_aborted;
    logic       cur_write;
    logic       cpu_req;
    logic       cpu_pending;

    // Refresh cycles look like memory requests on the Z80 bus but are
    // never serviced.
    assign cpu_req     = ~cpu_mreq_n & cpu_rfsh_n & (~cpu_rd_n | ~cpu_wr_n);
    assign cpu_pending = cpu_req & ~cpu_done;

    // Gated by reset_n so the CPU is never stalled while reset is held.
    assign cpu_wait_n  = ~(reset_n & cpu_pending);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            streak      <= '0;
            cpu_done    <= 1'b0;
            cpu_aborted <= 1'b0;
            cur_write   <= 1'b0;
            cpu_di      <= '0;
            vid_ack     <= 1'b0;
            vid_data    <= '0;
            mem_addr    <= '0;
            mem_dout    <= '0;
            mem_oe      <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            if (cpu_mreq_n) begin
                cpu_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cpu_pending && (!vid_req || streak == STREAK_MAX)) begin
                        state       <= CPU;
                        mem_addr    <= cpu_a;
                        cnt         <= '0;
                        streak      <= '0;
                        cpu_aborted <= 1'b0;
                        // Write wins when both strobes are low.
                        if (!cpu_wr_n) begin
                            cur_write <= 1'b1;
                            mem_dout  <= cpu_dout;
                            mem_we    <= 1'b1;
                        end else begin
                            cur_write <= 1'b0;
                            mem_oe    <= 1'b1;
                        end
                    end else if (vid_req) begin
                        state    <= VID;
                        mem_addr <= vid_addr;
                        mem_oe   <= 1'b1;
                        cnt      <= '0;
                        if (!cpu_pending) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 4'd1;
                        end
                    end else begin
                        streak <= '0;
                    end
                end

                VID: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_CNT) begin
                        mem_oe   <= 1'b0;
                        vid_data <= mem_din;
                        vid_ack  <= 1'b1;
                        state    <= IDLE;
                    end
                end

                CPU: begin
                    cnt <= cnt + 3'd1;
                    // Remember an mreq release mid-access so a new request
                    // raised before completion never receives this result.
                    if (cpu_mreq_n) begin
                        cpu_aborted <= 1'b1;
                    end
                    if (cnt == LAST_CNT) begin
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= IDLE;
                        if (!cpu_aborted && !cpu_mreq_n) begin
                            cpu_done <= 1'b1;
                            if (!cur_write) begin
                                cpu_di <= mem_din;
                            end
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    mem_oe <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
